// File: rtl/machine_display.sv
// machine_display: scans a 20-bit machine state snapshot onto a 4-digit
// common-anode seven-segment display, with cursor dots and LEDs.
module machine_display #(
   parameter int DIV   = 50000,
   parameter int BLANK = 500
) (
   input  logic        system1000,
   input  logic        system1000_rstn,
   input  logic [19:0] s,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  led,
   output logic        frame
);
   localparam int CW = $clog2(DIV);
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [19:0]   shadow_q, shadow_d;
   logic [3:0]    an_q, an_d, led_q, nib;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d, frame_q, frame_d, wrap;
   always_comb begin
      wrap     = cnt_q == CW'(DIV - 1);
      cnt_d    = wrap ? '0 : cnt_q + 1'b1;
      idx_d    = wrap ? idx_q + 2'd1 : idx_q;
      frame_d  = wrap && idx_q == 2'd3;
      shadow_d = frame_d ? s : shadow_q;
      nib      = idx_q == 2'd0 ? shadow_q[19:16] :
                 idx_q == 2'd1 ? shadow_q[15:12] :
                 idx_q == 2'd2 ? shadow_q[11:8]  : shadow_q[7:4];
      // anodes stay dark during the dead time; seg/dp already carry the slot
      an_d     = cnt_q < CW'(BLANK) ? 4'b1111 : ~(4'b1000 >> idx_q);
      seg_d    = SEG_LUT[nib];
      dp_d     = ~shadow_q[2'd3 - idx_q];
   end
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         an_q     <= 4'b1111;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
         led_q    <= '0;
         frame_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         led_q    <= shadow_q[3:0];
         frame_q  <= frame_d;
      end
   end
   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign led   = led_q;
   assign frame = frame_q;
endmodule

// File: doc/machine_display.md
Name: machine_display

Overview:
- Output-side reader of the 20-bit machine state produced by the update logic.
- State layout: four digit nibbles s[19:16], s[15:12], s[11:8], s[7:4], plus a one-hot rotating cursor nibble s[3:0].
- The block time-multiplexes the four digit nibbles onto a 4-digit common-anode seven-segment display. The cursor nibble is shown as the decimal point of the selected digit and mirrored on four LEDs.
- It takes a coherent snapshot of the state once per scan frame, so the display never shows a torn update.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range DIV >= 2.
- BLANK, 500, dead-time cycles at the start of each slot during which all anodes are off; legal range 0 <= BLANK < DIV.

Ports:
- system1000  input  1  system clock
- system1000_rstn  input  1  asynchronous reset, active-low
- s  input  20  machine state, sampled only at frame boundaries
- an  output  4  digit anodes, active-low; an[3] = leftmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- led  output  4  registered copy of shadow[3:0]
- frame  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (asynchronous, while system1000_rstn=0): an=4'b1111, seg=7'b1111111, dp=1, led=4'b0000, frame=0. Internal registers cnt=0, idx=0, shadow=20'h0.
  - Reset asserted mid-scan takes effect immediately.
  - After release, scanning restarts at idx=0, cnt=0, showing shadow=0 until the first snapshot.
- Prescaler: cnt counts 0..DIV-1 and wraps. When cnt==DIV-1, idx advances 0->1->2->3->0.
- Snapshot: on the edge where cnt==DIV-1 and idx==3, shadow <= s. Also on that edge, frame <= 1; frame is 0 on every other edge.
  - Changes on s at any other time are ignored until the next frame boundary.
  - First snapshot occurs 4*DIV cycles after reset release.
- Digit select: slot idx=i selects nibble n = shadow[19-4i -: 4] and anode an[3-i].
- Outputs an, seg, dp are registered from (cnt, idx, shadow). They reflect the state one cycle late: latency 1 clock.
- Blanking: when cnt < BLANK, an=4'b1111. seg and dp still carry the slot's value. When cnt >= BLANK, exactly one anode is low (one-hot-low).
  - BLANK=0 disables blanking.
- Decode (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Decimal point: dp=0 in slot i iff shadow[3-i]==1.
  - The cursor nibble is not required to be one-hot. Every set bit lights its digit's dp; 0000 lights none.
- led <= shadow[3:0] every cycle. It therefore changes one cycle after a snapshot.
- No combinational path from s to any output.
- All counters are sized from DIV. No overflow beyond DIV-1 is reachable.

Test Plan:
- Reset: hold system1000_rstn=0 for 3 cycles with s=20'hFFFFF -> an=1111, seg=7F, dp=1, led=0, frame=0. After release with DIV=4, BLANK=1:
  - first frame shows digit 0 on all four slots with no dp lit;
  - frame pulses exactly at cycle 16 (1-based count after release, including the 1-cycle output latency).
- Scan order (DIV=4, BLANK=1, s=20'h1234_8):
  - after the first frame pulse, slots in order show an=0111/seg=79/dp=0, an=1011/seg=24/dp=1, an=1101/seg=30/dp=1, an=1110/seg=19/dp=1;
  - each slot has an=1111 for exactly its first cycle;
  - led=1000.
- Decode sweep: step s[19:16] through 0..F, one per frame -> leftmost digit seg matches the 16-entry table above.
- Snapshot coherence: change s from 20'hAAAA1 to 20'h55552 two cycles after a frame pulse -> remaining slots of that frame still show A, with dp on the rightmost digit. The next frame shows 5, with dp on the third digit. led changes to 0010 one cycle after the pulse.
- Reset mid-scan: assert reset at idx=2, cnt=1 -> outputs return to reset values in the same cycle (asynchronous). After release, scanning restarts at an[3] and the snapshot is cleared to 0.
- Cursor edge cases: s[3:0]=0000 -> dp=1 in all slots. s[3:0]=1111 -> dp=0 in all slots.
